// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK instruction sequencer
//
// Owns the timing of state-element updates for the core: issues imem/dmem
// request handshakes and the IR / regfile / PC write strobes. Memory hangs
// and illegal opcodes park the sequencer in HALT with an error code.
//
// Optional feature macro: PERF_CNT_EN (adds cycle_cnt / retire_cnt outputs).
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   run                   permit start of the next instruction fetch
//   opcode[5:0]           IR[31:26], valid from DECODE onward
//   alu_zero              ALU zero flag, used by BRANCH in EXECUTE
//   imem_req/imem_ready   instruction fetch handshake
//   dmem_req/dmem_we      data access request, 1=store 0=load
//   dmem_ready            data access complete
//   ir_write, reg_write   IR latch and regfile write strobes
//   pc_write, pc_src[1:0] PC update strobe and source (00 +4, 01 branch, 10 jump)
//   stage[2:0]            current state encoding
//   halted, err_code[1:0] HALT flag; 00 none, 01 illegal, 10 imem timeout, 11 dmem timeout
//   cycle_cnt, retire_cnt performance counters (PERF_CNT_EN only)

module multicycle_sequencer #(
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic       alu_zero,
  output logic       imem_req,
  input  logic       imem_ready,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  output logic       ir_write,
  output logic       reg_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [2:0] stage,
  output logic       halted,
  output logic [1:0] err_code
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] retire_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_NOP, C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_HALT, C_ILLEGAL
  } cls_t;

  state_t      state, state_next;
  cls_t        cls;
  logic        req_pending, req_pending_next;
  logic [1:0]  err_q, err_next;
  logic [31:0] tcount;
  logic        req_wait;
  logic        expire;

  always_comb begin
    case (opcode)
      6'h00:                      cls = C_NOP;
      6'h01, 6'h02,
      6'h03, 6'h04, 6'h05, 6'h06: cls = C_ALU;
      6'h07:                      cls = C_LOAD;
      6'h08:                      cls = C_STORE;
      6'h0B:                      cls = C_BRANCH;
      6'h0C, 6'h0D:               cls = C_JUMP;
      6'h0E:                      cls = C_HALT;
      default:                    cls = C_ILLEGAL;
    endcase
  end

  // A request is "waiting" on any cycle it is raised without its ready.
  // Expiry fires on the TIMEOUT-th such cycle; a ready in that same cycle
  // is taken first, so it completes normally.
  always_comb begin
    req_wait = 1'b0;
    if (state == S_FETCH)
      req_wait = (run | req_pending) & ~imem_ready;
    else if (state == S_MEMORY)
      req_wait = ~dmem_ready;
  end

  assign expire = (TIMEOUT != 0) && req_wait && (tcount == 32'(TIMEOUT - 1));

  always_comb begin
    state_next       = state;
    req_pending_next = 1'b0;
    err_next         = err_q;
    imem_req         = 1'b0;
    dmem_req         = 1'b0;
    dmem_we          = 1'b0;
    ir_write         = 1'b0;
    reg_write        = 1'b0;
    pc_write         = 1'b0;
    pc_src           = 2'b00;
    halted           = 1'b0;

    case (state)
      S_FETCH: begin
        // Once issued the request is held regardless of run.
        imem_req = run | req_pending;
        if (imem_req && imem_ready) begin
          ir_write   = 1'b1;
          state_next = S_DECODE;
        end else if (expire) begin
          imem_req   = 1'b1;
          err_next   = 2'b10;
          state_next = S_HALT;
        end else begin
          req_pending_next = imem_req;
        end
      end

      S_DECODE: begin
        case (cls)
          C_NOP: begin
            pc_write   = 1'b1;
            state_next = S_FETCH;
          end
          C_JUMP: begin
            pc_write   = 1'b1;
            pc_src     = 2'b10;
            state_next = S_FETCH;
          end
          C_HALT:    state_next = S_HALT;
          C_ILLEGAL: begin
            err_next   = 2'b01;
            state_next = S_HALT;
          end
          default:   state_next = S_EXECUTE;
        endcase
      end

      S_EXECUTE: begin
        case (cls)
          C_BRANCH: begin
            pc_write   = 1'b1;
            pc_src     = alu_zero ? 2'b01 : 2'b00;
            state_next = S_FETCH;
          end
          C_ALU:            state_next = S_WRITEBACK;
          C_LOAD, C_STORE:  state_next = S_MEMORY;
          // Opcode changed under a latched IR: treat as illegal rather than guess.
          default: begin
            err_next   = 2'b01;
            state_next = S_HALT;
          end
        endcase
      end

      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == C_STORE);
        if (dmem_ready) begin
          if (cls == C_STORE) begin
            pc_write   = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WRITEBACK;
          end
        end else if (expire) begin
          err_next   = 2'b11;
          state_next = S_HALT;
        end
      end

      S_WRITEBACK: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        state_next = S_FETCH;
      end

      default: begin
        halted = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      req_pending <= 1'b0;
      err_q       <= 2'b00;
      tcount      <= 32'd0;
    end else begin
      state       <= state_next;
      req_pending <= req_pending_next;
      err_q       <= err_next;
      if (state_next != state)
        tcount <= 32'd0;
      else if (req_wait)
        tcount <= tcount + 32'd1;
    end
  end

  assign stage    = state;
  assign err_code = err_q;

`ifdef PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      if (!halted)
        cycle_cnt <= cycle_cnt + 1'b1;
      if (pc_write)
        retire_cnt <= retire_cnt + 1'b1;
    end
  end
`else
  logic unused_cnt_width;
  assign unused_cnt_width = (CNT_WIDTH > 0);
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - scoreboard bench for multicycle_sequencer

module tb_multicycle_sequencer;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset, run, alu_zero, imem_ready, dmem_ready;
  logic [5:0] opcode;
  logic       imem_req, dmem_req, dmem_we, ir_write, reg_write, pc_write, halted;
  logic [1:0] pc_src, err_code;
  logic [2:0] stage;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, retire_cnt;
`endif

  multicycle_sequencer #(.TIMEOUT(TO), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .alu_zero(alu_zero),
    .imem_req(imem_req), .imem_ready(imem_ready), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_ready(dmem_ready), .ir_write(ir_write),
    .reg_write(reg_write), .pc_write(pc_write), .pc_src(pc_src),
    .stage(stage), .halted(halted), .err_code(err_code)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, run, ir, dm, z;
    logic [5:0]  op;
    logic [13:0] exp;
    int          step;
  } ent_t;

  ent_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   nstep    = 0;

  task automatic check_eq(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // {stage, imem_req, dmem_req, dmem_we, ir_write, reg_write, pc_write, pc_src, halted, err_code}
  function automatic logic [13:0] o(input int st, input int ireq, input int dreq, input int we,
                                    input int irw, input int rw, input int pcw, input int src,
                                    input int h, input int err);
    return {3'(st), 1'(ireq), 1'(dreq), 1'(we), 1'(irw), 1'(rw), 1'(pcw), 2'(src), 1'(h), 2'(err)};
  endfunction

  task automatic add(input int rst, input int rn, input int ir, input int dm, input int z,
                     input logic [5:0] op, input logic [13:0] exp);
    ent_t e;
    e.rst = 1'(rst); e.run = 1'(rn); e.ir = 1'(ir); e.dm = 1'(dm); e.z = 1'(z);
    e.op = op; e.exp = exp; e.step = nstep;
    nstep++;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 6'h00, o(0,0,0,0,0,0,0,0,0,0));
  endtask

  // HALT must ignore run and readys; only reset leaves it.
  task automatic halt_seq(input int err, input logic [5:0] op);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 1, 0, op, o(5,0,0,0,0,0,0,0,1,err));
    add(1, 0, 0, 0, 0, op, o(5,0,0,0,0,0,0,0,1,err));
    idle(1);
  endtask

  // Expected per-cycle trace of one instruction; run is raised only in the first fetch cycle.
  task automatic gen(input logic [5:0] op, input int idly, input int ddly, input int z);
    bit alu, ld, st;
    alu = (op >= 6'h01 && op <= 6'h06);
    ld  = (op == 6'h07);
    st  = (op == 6'h08);
    if (idly >= TO) begin
      for (int i = 0; i < TO; i++) add(0, i == 0, 0, 0, z, op, o(0,1,0,0,0,0,0,0,0,0));
      halt_seq(2, op);
      return;
    end
    for (int i = 0; i <= idly; i++)
      add(0, i == 0, i == idly, 0, z, op, o(0,1,0,0,i == idly,0,0,0,0,0));
    if (op == 6'h00) begin add(0,0,0,0,z,op, o(1,0,0,0,0,0,1,0,0,0)); return; end
    if (op == 6'h0C || op == 6'h0D) begin add(0,0,0,0,z,op, o(1,0,0,0,0,0,1,2,0,0)); return; end
    add(0, 0, 0, 0, z, op, o(1,0,0,0,0,0,0,0,0,0));
    if (op == 6'h0E) begin halt_seq(0, op); return; end
    if (!(alu || ld || st || op == 6'h0B)) begin halt_seq(1, op); return; end
    if (op == 6'h0B) begin add(0,0,0,0,z,op, o(2,0,0,0,0,0,1,z ? 1 : 0,0,0)); return; end
    add(0, 0, 0, 0, z, op, o(2,0,0,0,0,0,0,0,0,0));
    if (ld || st) begin
      if (ddly >= TO) begin
        for (int i = 0; i < TO; i++) add(0, 0, 0, 0, z, op, o(3,0,1,st,0,0,0,0,0,0));
        halt_seq(3, op);
        return;
      end
      for (int i = 0; i <= ddly; i++)
        add(0, 0, 0, i == ddly, z, op, o(3,0,1,st,0,0,st && i == ddly,0,0,0));
      if (st) return;
    end
    add(0, 0, 0, 0, z, op, o(4,0,0,0,0,1,1,0,0,0));
  endtask

  initial begin
    ent_t e;
    logic [13:0] obs;
    reset = 1'b1; run = 1'b0; alu_zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    opcode = 6'h00;

    idle(2);
    gen(6'h01, 0, 0, 0);
    gen(6'h05, 2, 0, 0);
    gen(6'h07, 0, 3, 0);
    gen(6'h08, 1, 0, 0);
    gen(6'h0B, 0, 0, 1);
    gen(6'h0B, 0, 0, 0);
    gen(6'h0C, 0, 0, 0);
    gen(6'h0D, 3, 0, 1);
    gen(6'h00, 0, 0, 0);
    gen(6'h07, 0, TO - 1, 0);
    gen(6'h08, TO - 1, 2, 0);
    // Reset in the third MEMORY cycle of a load: abandon, no pc_write.
    add(0, 1, 1, 0, 0, 6'h07, o(0,1,0,0,1,0,0,0,0,0));
    add(0, 0, 0, 0, 0, 6'h07, o(1,0,0,0,0,0,0,0,0,0));
    add(0, 0, 0, 0, 0, 6'h07, o(2,0,0,0,0,0,0,0,0,0));
    add(0, 0, 0, 0, 0, 6'h07, o(3,0,1,0,0,0,0,0,0,0));
    add(0, 0, 0, 0, 0, 6'h07, o(3,0,1,0,0,0,0,0,0,0));
    add(1, 0, 0, 0, 0, 6'h07, o(3,0,1,0,0,0,0,0,0,0));
    idle(2);
    gen(6'h09, 0, 0, 0);
    gen(6'h0E, 1, 0, 0);
    gen(6'h02, TO, 0, 0);
    gen(6'h08, 0, TO + 5, 0);
    gen(6'h3F, 0, 0, 0);
    gen(6'h0A, 0, 0, 0);
    gen(6'h03, 0, 0, 0);

    repeat (2) @(posedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      @(posedge clk);
      #1;
      reset = e.rst; run = e.run; imem_ready = e.ir; dmem_ready = e.dm;
      alu_zero = e.z; opcode = e.op;
      @(negedge clk);
      obs = {stage, imem_req, dmem_req, dmem_we, ir_write, reg_write, pc_write,
             pc_src, halted, err_code};
      check_eq($sformatf("op%02h_step%0d", e.op, e.step), obs, e.exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
